// File: rtl/itgnet_frame_sched_pkg.sv
// rtl/itgnet_frame_sched_pkg.sv - shared helpers and FSM state encoding for the ItgNet frame sequencer
package itgnet_frame_sched_pkg;

    // Ceiling log2. Never returns less than 1, so a value of 1 or 2 still
    // yields a usable one-bit vector.
    function automatic int log2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/itgnet_frame_sched_raster_counter.sv
// rtl/itgnet_frame_sched_raster_counter.sv - wrapping (line, pixel) raster counter
//
// Ports:
//   clock, n_rst : clock, asynchronous active-low reset
//   inc          : advance one pixel in raster order
//   clr          : return to (0,0); wins over inc
//   vcnt, hcnt   : current line / pixel position
//   last         : current position is the final pixel of the frame
module raster_counter
    import itgnet_frame_sched_pkg::*;
#(
    parameter int W_HEIGHT = 2,
    parameter int W_WIDTH  = 2,
    localparam int V_BITW  = log2(W_HEIGHT),
    localparam int H_BITW  = log2(W_WIDTH)
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic              inc,
    input  logic              clr,
    output logic [V_BITW-1:0] vcnt,
    output logic [H_BITW-1:0] hcnt,
    output logic              last
);

    localparam logic [V_BITW-1:0] V_MAX = V_BITW'(W_HEIGHT - 1);
    localparam logic [H_BITW-1:0] H_MAX = H_BITW'(W_WIDTH - 1);

    logic [V_BITW-1:0] vcnt_q, vcnt_d;
    logic [H_BITW-1:0] hcnt_q, hcnt_d;

    always_comb begin
        vcnt_d = vcnt_q;
        hcnt_d = hcnt_q;
        if (clr) begin
            vcnt_d = '0;
            hcnt_d = '0;
        end else if (inc) begin
            if (hcnt_q == H_MAX) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_MAX) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            vcnt_q <= '0;
            hcnt_q <= '0;
        end else begin
            vcnt_q <= vcnt_d;
            hcnt_q <= hcnt_d;
        end
    end

    assign vcnt = vcnt_q;
    assign hcnt = hcnt_q;
    assign last = (vcnt_q == V_MAX) && (hcnt_q == H_MAX);

endmodule

// File: rtl/itgnet_frame_sched.sv
// rtl/itgnet_frame_sched.sv - per-frame sequencer feeding the ItgNet CNN raster with tail flush
//
// Ports:
//   clock, n_rst           : clock, asynchronous active-low reset
//   start                  : begin-frame pulse, only honoured when idle
//   src_valid / src_ready  : upstream pixel handshake (ready only while feeding)
//   pad_sel                : datapath selects zero instead of the source pixel
//   cnn_enable/vcnt/hcnt   : registered raster drive into the CNN input
//   res_enable/vcnt/hcnt   : CNN output coordinates, watched for the final pixel
//   busy                   : frame in progress (start accepted until done)
//   done                   : one-cycle end-of-frame pulse
//   err                    : sticky drain timeout, cleared by the next accepted start
module itgnet_frame_sched
    import itgnet_frame_sched_pkg::*;
#(
    parameter int W_HEIGHT   = -1,
    parameter int W_WIDTH    = -1,
    parameter int PATCH_SIZE = -1,
    parameter int TIMEOUT    = 65535,
    localparam int V_BITW    = log2(W_HEIGHT),
    localparam int H_BITW    = log2(W_WIDTH)
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic              start,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              pad_sel,
    output logic              cnn_enable,
    output logic [V_BITW-1:0] cnn_vcnt,
    output logic [H_BITW-1:0] cnn_hcnt,
    input  logic              res_enable,
    input  logic [V_BITW-1:0] res_vcnt,
    input  logic [H_BITW-1:0] res_hcnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Enough zero pixels to push the last valid window through every
    // line-buffered layer of the network.
    localparam int FLUSH_CYCLES = (PATCH_SIZE - 1) * 2 * (W_WIDTH + 1);
    localparam int F_BITW       = log2(FLUSH_CYCLES + 1);
    localparam int T_BITW       = log2(TIMEOUT + 1);

    localparam logic [F_BITW-1:0] FLUSH_LAST = F_BITW'(FLUSH_CYCLES - 1);
    localparam logic [T_BITW-1:0] DRAIN_MAX  = T_BITW'(TIMEOUT);
    localparam logic [V_BITW-1:0] V_MAX      = V_BITW'(W_HEIGHT - 1);
    localparam logic [H_BITW-1:0] H_MAX      = H_BITW'(W_WIDTH - 1);

    state_e            state_q, state_d;
    logic [F_BITW-1:0] flush_cnt_q, flush_cnt_d;
    logic [T_BITW-1:0] drain_cnt_q, drain_cnt_d;
    logic              res_seen_q, res_seen_d;
    logic              err_q, err_d;
    logic              cnn_enable_q, cnn_enable_d;
    logic              pad_sel_q, pad_sel_d;
    logic [V_BITW-1:0] cnn_vcnt_q, cnn_vcnt_d;
    logic [H_BITW-1:0] cnn_hcnt_q, cnn_hcnt_d;

    logic              rc_inc;
    logic              rc_clr;
    logic [V_BITW-1:0] rc_vcnt;
    logic [H_BITW-1:0] rc_hcnt;
    logic              rc_last;

    logic              handshake;
    logic              res_last;

    raster_counter #(
        .W_HEIGHT (W_HEIGHT),
        .W_WIDTH  (W_WIDTH)
    ) u_in_raster (
        .clock (clock),
        .n_rst (n_rst),
        .inc   (rc_inc),
        .clr   (rc_clr),
        .vcnt  (rc_vcnt),
        .hcnt  (rc_hcnt),
        .last  (rc_last)
    );

    // Ready comes straight from the state register, never from src_valid.
    assign src_ready = (state_q == ST_FEED);
    assign handshake = src_valid && src_ready;
    assign res_last  = res_enable && (res_vcnt == V_MAX) && (res_hcnt == H_MAX);

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        drain_cnt_d  = '0;
        res_seen_d   = res_seen_q;
        err_d        = err_q;
        cnn_enable_d = 1'b0;
        pad_sel_d    = 1'b0;
        cnn_vcnt_d   = cnn_vcnt_q;
        cnn_hcnt_d   = cnn_hcnt_q;
        rc_inc       = 1'b0;
        rc_clr       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                flush_cnt_d = '0;
                res_seen_d  = 1'b0;
                if (start) begin
                    state_d = ST_FEED;
                    err_d   = 1'b0;
                    rc_clr  = 1'b1;
                end
            end

            ST_FEED: begin
                if (handshake) begin
                    cnn_enable_d = 1'b1;
                    cnn_vcnt_d   = rc_vcnt;
                    cnn_hcnt_d   = rc_hcnt;
                    rc_inc       = 1'b1;
                    if (rc_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end

            ST_FLUSH: begin
                cnn_enable_d = 1'b1;
                pad_sel_d    = 1'b1;
                cnn_vcnt_d   = rc_vcnt;
                cnn_hcnt_d   = rc_hcnt;
                rc_inc       = 1'b1;
                flush_cnt_d  = flush_cnt_q + 1'b1;
                // An early final result is remembered, but the flush is
                // never cut short.
                if (res_last) begin
                    res_seen_d = 1'b1;
                end
                if (flush_cnt_q == FLUSH_LAST) begin
                    flush_cnt_d = '0;
                    state_d     = (res_seen_q || res_last) ? ST_DONE : ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (res_last) begin
                    state_d = ST_DONE;
                end else if (drain_cnt_d == DRAIN_MAX) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end

            ST_DONE: begin
                rc_clr     = 1'b1;
                res_seen_d = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            flush_cnt_q  <= '0;
            drain_cnt_q  <= '0;
            res_seen_q   <= 1'b0;
            err_q        <= 1'b0;
            cnn_enable_q <= 1'b0;
            pad_sel_q    <= 1'b0;
            cnn_vcnt_q   <= '0;
            cnn_hcnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            res_seen_q   <= res_seen_d;
            err_q        <= err_d;
            cnn_enable_q <= cnn_enable_d;
            pad_sel_q    <= pad_sel_d;
            cnn_vcnt_q   <= cnn_vcnt_d;
            cnn_hcnt_q   <= cnn_hcnt_d;
        end
    end

    assign cnn_enable = cnn_enable_q;
    assign pad_sel    = pad_sel_q;
    assign cnn_vcnt   = cnn_vcnt_q;
    assign cnn_hcnt   = cnn_hcnt_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_itgnet_frame_sched.sv
// tb/tb_itgnet_frame_sched.sv - directed self-checking bench for itgnet_frame_sched
module tb_itgnet_frame_sched;

    localparam int W_HEIGHT = 4;
    localparam int W_WIDTH  = 6;
    localparam int N_PIX    = W_HEIGHT * W_WIDTH;   // 24
    localparam int N_FLUSH  = 14;                   // (2-1)*2*(6+1)

    logic       clock = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic       pad_sel;
    logic       cnn_enable;
    logic [1:0] cnn_vcnt;
    logic [2:0] cnn_hcnt;
    logic       res_enable;
    logic [1:0] res_vcnt;
    logic [2:0] res_hcnt;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clock = ~clock;

    itgnet_frame_sched #(
        .W_HEIGHT   (W_HEIGHT),
        .W_WIDTH    (W_WIDTH),
        .PATCH_SIZE (2),
        .TIMEOUT    (200)
    ) dut (
        .clock      (clock),
        .n_rst      (n_rst),
        .start      (start),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .pad_sel    (pad_sel),
        .cnn_enable (cnn_enable),
        .cnn_vcnt   (cnn_vcnt),
        .cnn_hcnt   (cnn_hcnt),
        .res_enable (res_enable),
        .res_vcnt   (res_vcnt),
        .res_hcnt   (res_hcnt),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // CNN stand-in: returns the input raster as results res_delay cycles later.
    bit         model_on  = 1'b0;
    int         res_delay = 20;
    logic       en_pipe [0:31];
    logic [1:0] v_pipe  [0:31];
    logic [2:0] h_pipe  [0:31];

    always @(posedge clock) begin
        if (!n_rst) begin
            for (int i = 0; i < 32; i++) begin
                en_pipe[i] <= 1'b0;
                v_pipe[i]  <= '0;
                h_pipe[i]  <= '0;
            end
        end else begin
            en_pipe[0] <= cnn_enable;
            v_pipe[0]  <= cnn_vcnt;
            h_pipe[0]  <= cnn_hcnt;
            for (int i = 1; i < 32; i++) begin
                en_pipe[i] <= en_pipe[i-1];
                v_pipe[i]  <= v_pipe[i-1];
                h_pipe[i]  <= h_pipe[i-1];
            end
        end
    end

    assign res_enable = model_on & en_pipe[res_delay-1];
    assign res_vcnt   = v_pipe[res_delay-1];
    assign res_hcnt   = h_pipe[res_delay-1];

    // Output monitor: every enable must follow raster order (0,0),(0,1)..,
    // the first 24 of a frame real pixels, the rest padding.
    int cyc = 0;
    int en_idx = 0;
    int feed_cnt = 0;
    int pad_cnt = 0;
    int hs_cnt = 0;
    int coord_errs = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int first_pad_cyc = 0;
    int last_pad_cyc = 0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (!n_rst) begin
            en_idx   = 0;
            feed_cnt = 0;
            pad_cnt  = 0;
            hs_cnt   = 0;
        end else begin
            if (start && !busy) begin
                en_idx   = 0;
                feed_cnt = 0;
                pad_cnt  = 0;
                hs_cnt   = 0;
            end
            if (src_valid && src_ready) begin
                hs_cnt = hs_cnt + 1;
            end
            if (cnn_enable) begin
                if (int'(cnn_vcnt) != (en_idx / W_WIDTH) % W_HEIGHT ||
                    int'(cnn_hcnt) != en_idx % W_WIDTH ||
                    pad_sel != (en_idx >= N_PIX)) begin
                    coord_errs = coord_errs + 1;
                end
                if (pad_sel) begin
                    if (pad_cnt == 0) first_pad_cyc = cyc;
                    last_pad_cyc = cyc;
                    pad_cnt = pad_cnt + 1;
                end else begin
                    feed_cnt = feed_cnt + 1;
                end
                en_idx = en_idx + 1;
            end else if (pad_sel) begin
                coord_errs = coord_errs + 1;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
                en_idx   = 0;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit valid_mode = 1'b0;   // 0: src_valid held high, 1: toggles every cycle

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        if (!valid_mode) src_valid = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs until done; optional start pulse during FEED (start_at >= 0) and
    // during the DONE cycle itself.
    task automatic run_until_done(input int budget, input int start_at, input bit start_in_done);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            start     = (i == start_at);
            src_valid = valid_mode ? ~src_valid : 1'b1;
            tick();
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else if (start_in_done) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("start_in_done_ignored", busy, 0);
        end
    endtask

    // Full frame with the usual end-of-frame checks; exp_gap is the cycle
    // distance from the first pad enable to the done pulse.
    task automatic frame(input string tag, input int exp_gap, input int start_at, input bit start_in_done);
        int dc;
        dc = done_cnt;
        do_start();
        chk({tag, "_busy_after_start"}, busy, 1);
        chk({tag, "_ready_in_feed"}, src_ready, 1);
        run_until_done(400, start_at, start_in_done);
        idle(2);
        chk({tag, "_done_pulses"}, done_cnt - dc, 1);
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_feed_enables"}, feed_cnt, N_PIX);
        chk({tag, "_handshakes"}, hs_cnt, N_PIX);
        chk({tag, "_pad_enables"}, pad_cnt, N_FLUSH);
        chk({tag, "_raster_errs"}, coord_errs, 0);
        chk({tag, "_done_gap"}, done_cyc - first_pad_cyc, exp_gap);
    endtask

    initial begin
        // Reset state
        idle(3);
        chk("rst_outputs", {src_ready, pad_sel, cnn_enable, cnn_vcnt, cnn_hcnt, busy, done, err}, 0);
        n_rst = 1'b1;
        idle(2);
        chk("idle_busy", busy, 0);
        chk("idle_ready", src_ready, 0);
        chk("idle_err", err, 0);

        // 1: valid held, result returns 20 cycles after the last pixel leaves,
        // landing in DRAIN: done 20 cycles after the first pad enable.
        model_on  = 1'b1;
        res_delay = 20;
        frame("t1", 20, -1, 1'b0);
        chk("t1_err", err, 0);
        idle(40);

        // 2: valid toggling in FEED
        valid_mode = 1'b1;
        src_valid  = 1'b0;
        frame("t2", 20, -1, 1'b0);
        valid_mode = 1'b0;
        idle(40);

        // 3: start pulses during FEED and DONE are ignored; next frame restarts at (0,0)
        frame("t3a", 20, 5, 1'b1);
        idle(2);
        chk("t3_still_idle", busy, 0);
        idle(40);
        frame("t3b", 20, -1, 1'b0);
        idle(40);

        // 4: result never returns -> timeout 200 cycles after DRAIN entry.
        // DRAIN entry coincides with the last pad enable leaving the register.
        model_on = 1'b0;
        do_start();
        run_until_done(400, -1, 1'b0);
        chk("t4_err_at_done", err, 1);
        idle(2);
        chk("t4_drain_cycles", done_cyc - last_pad_cyc, 200);
        chk("t4_pad_enables", pad_cnt, N_FLUSH);
        idle(40);
        chk("t4_err_sticky", err, 1);
        model_on = 1'b1;
        do_start();
        chk("t4_err_cleared", err, 0);
        run_until_done(400, -1, 1'b0);
        idle(40);

        // 6: final result during flush cycle 10: flush completes, done right after
        res_delay = 10;
        frame("t6", 13, -1, 1'b0);
        chk("t6_err", err, 0);
        res_delay = 20;
        idle(40);

        // 5: reset mid-FLUSH aborts silently
        begin
            int dc;
            bit in_flush;
            dc = done_cnt;
            in_flush = 1'b0;
            do_start();
            for (int i = 0; i < 60 && !in_flush; i++) begin
                tick();
                if (pad_sel) in_flush = 1'b1;
            end
            chk("t5_reached_flush", in_flush, 1);
            idle(3);
            #2;
            n_rst = 1'b0;
            #1;
            chk("t5_rst_outputs", {src_ready, pad_sel, cnn_enable, cnn_vcnt, cnn_hcnt, busy, done, err}, 0);
            idle(2);
            n_rst = 1'b1;
            idle(40);
            chk("t5_no_done", done_cnt - dc, 0);
            chk("t5_idle", busy, 0);
            frame("t5r", 20, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
